hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage RISC-V pipeline. It drives the stall and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the EX-stage forwarding muxes. It also sequences multi-cycle data-memory accesses in the M stage with a bounded wait and timeout. Saturating performance counters record stall and flush activity.

Parameters:
TIMEOUT, 16, max consecutive stall cycles allowed for one M-stage memory access (>=2)
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
Rs1D  in  5  source reg 1 of instruction in D
Rs2D  in  5  source reg 2 of instruction in D
Rs1E  in  5  source reg 1 of instruction in E
Rs2E  in  5  source reg 2 of instruction in E
RdE  in  5  destination reg in E
RdM  in  5  destination reg in M
RdW  in  5  destination reg in W
RegWriteM  in  1  M instruction writes the register file
RegWriteW  in  1  W instruction writes the register file
ResultSrcE0  in  1  E instruction is a load (ResultSrcE[0])
PCSrcE  in  1  taken branch/jump resolved in E
MemReqM  in  1  M instruction accesses data memory
MemReadyM  in  1  data memory completes the access this cycle
clr_cnt  in  1  synchronous clear of the counters
ForwardAE  out  2  SrcA select: 00 regfile, 01 W result, 10 M ALU result
ForwardBE  out  2  SrcB select, same encoding
StallF  out  1  hold PC
StallD  out  1  hold IF/ID
StallE  out  1  hold ID/EX
StallM  out  1  hold EX/MEM
FlushD  out  1  clear IF/ID
FlushE  out  1  clear ID/EX
FlushW  out  1  clear MEM/WB (inject a bubble)
mem_err  out  1  sticky memory-timeout flag
stall_cnt  out  CNT_W  count of cycles with StallF=1
flush_cnt  out  CNT_W  count of branch-flush cycles

Behaviour:
- Reset: clk and reset are decided as stated in Ports (reset asynchronous, active-high). While reset is asserted: state=RUN, wait_cnt=0, mem_err=0, stall_cnt=0, flush_cnt=0, all Stall*/Flush* outputs 0, ForwardAE/BE=00. Reset mid-wait abandons the wait immediately.
- Forwarding (combinational, shown for A; B uses Rs2E):
  - 10 if RegWriteM and RdM!=0 and RdM==Rs1E.
  - Otherwise 01 if RegWriteW and RdW!=0 and RdW==Rs1E.
  - Otherwise 00. M has priority over W.
- Load-use detection: lwStall = ResultSrcE0 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
- Memory stall (mem_stall), evaluated combinationally each cycle:
  - In RUN: mem_stall = MemReqM & !MemReadyM. When asserted: next state MEM_WAIT, wait_cnt<=1.
  - In MEM_WAIT, if MemReadyM or !MemReqM: mem_stall=0, next state RUN, wait_cnt<=0.
  - In MEM_WAIT, else if wait_cnt==TIMEOUT: mem_stall=0 (forced release), mem_err<=1, next state RUN, wait_cnt<=0.
  - In MEM_WAIT, else: mem_stall=1, wait_cnt++.
  - Result: at most TIMEOUT consecutive stall cycles per access. A ready response in the first cycle gives zero stall.
- Output priority:
  1. If mem_stall: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0. lwStall and PCSrcE are ignored that cycle; they are re-evaluated when the stall releases because E is held.
  2. Else if PCSrcE: FlushD=1, FlushE=1, all Stall*=0. A simultaneous lwStall is ignored because the D instruction is squashed.
  3. Else if lwStall: StallF=StallD=1, FlushE=1, other outputs 0.
  4. Else: all 0.
- Counters:
  - stall_cnt increments on every cycle with StallF=1.
  - flush_cnt increments on every cycle where priority 2 applies.
  - Both saturate at all-ones.
  - clr_cnt clears both to 0 next edge and takes precedence over an increment in the same cycle.
  - mem_err is cleared only by reset.

Test Plan:
- Forwarding: Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10. Change RdM=0 -> ForwardAE=01. RdW=0, RegWriteW=1, Rs2E=0 -> ForwardBE=00.
- Load-use: ResultSrcE0=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle; stall_cnt increments by 1. Same with RdE=0 -> no stall.
- Branch vs load-use: PCSrcE=1 with lwStall conditions true -> FlushD=FlushE=1, StallF=0; flush_cnt increments by 1 and stall_cnt is unchanged.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles, then 1 -> StallF/D/E/M and FlushW high for exactly 3 cycles, low on the ready cycle; stall_cnt=3, mem_err=0.
- Timeout: TIMEOUT=4, MemReqM=1, MemReadyM held 0 -> stall for exactly 4 cycles, released on the 5th; mem_err=1 from the following cycle and it stays 1 after the stall releases.
- Reset mid-wait and saturation: assert reset in the 2nd MEM_WAIT cycle -> all outputs 0 immediately, state RUN after release. Separately, with CNT_W=4, hold lwStall for 20 cycles -> stall_cnt=15. Then clr_cnt=1 concurrent with a stall -> stall_cnt=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forwarding control for a 5-stage RISC-V pipeline
//   with a bounded M-stage memory wait and saturating stall/flush counters.
// Ports:
//   clk, reset (async, active-high), clr_cnt
//   Rs1D/Rs2D, Rs1E/Rs2E/RdE, RdM/RdW, RegWriteM/W  : register hazard inputs
//   ResultSrcE0 (load in E), PCSrcE (taken branch)  : control hazard inputs
//   MemReqM/MemReadyM                               : M-stage memory handshake
//   ForwardAE/BE, Stall*, Flush*                    : pipeline controls
//   mem_err (sticky timeout), stall_cnt, flush_cnt  : status/perf counters
module hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  input  logic             clr_cnt,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic {RUN, MEM_WAIT} state_t;
  state_t           state_q, state_d;
  logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             lw_stall, at_limit, mem_stall, br_flush, ld_stall;
  function automatic logic [1:0] fwd(input logic [4:0] rs);
    return (RegWriteM && RdM != 5'd0 && RdM == rs) ? 2'b10 :
           (RegWriteW && RdW != 5'd0 && RdW == rs) ? 2'b01 : 2'b00;
  endfunction
  always_comb begin
    lw_stall    = ResultSrcE0 && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
    at_limit    = state_q == MEM_WAIT && wait_cnt_q == WW'(TIMEOUT);
    // outputs are gated by reset so an asserted reset silences them at once
    mem_stall   = !reset && MemReqM && !MemReadyM && !at_limit;
    br_flush    = !reset && !mem_stall && PCSrcE;
    ld_stall    = !reset && !mem_stall && !PCSrcE && lw_stall;
    ForwardAE   = reset ? 2'b00 : fwd(Rs1E);
    ForwardBE   = reset ? 2'b00 : fwd(Rs2E);
    StallF      = mem_stall || ld_stall;
    StallD      = mem_stall || ld_stall;
    StallE      = mem_stall;
    StallM      = mem_stall;
    FlushW      = mem_stall;
    FlushD      = br_flush;
    FlushE      = br_flush || ld_stall;
    state_d     = mem_stall ? MEM_WAIT : RUN;
    wait_cnt_d  = !mem_stall ? '0 : state_q == RUN ? WW'(1) : wait_cnt_q + WW'(1);
    // forced release at the limit while the access is still pending
    mem_err_d   = mem_err_q || (at_limit && MemReqM && !MemReadyM);
    stall_cnt_d = clr_cnt ? '0 : (StallF && ~&stall_cnt_q) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    flush_cnt_d = clr_cnt ? '0 : (br_flush && ~&flush_cnt_q) ? flush_cnt_q + 1'b1 : flush_cnt_q;
    mem_err     = mem_err_q;
    stall_cnt   = stall_cnt_q;
    flush_cnt   = flush_cnt_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scoreboard bench for hazard_ctrl (TIMEOUT=4, CNT_W=4)
module tb_hazard_ctrl;
  logic clk = 0, reset = 1;
  logic [4:0] Rs1D = 0, Rs2D = 0, Rs1E = 0, Rs2E = 0, RdE = 0, RdM = 0, RdW = 0;
  logic RegWriteM = 0, RegWriteW = 0, ResultSrcE0 = 0, PCSrcE = 0;
  logic MemReqM = 0, MemReadyM = 0, clr_cnt = 0;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err;
  logic [3:0] stall_cnt, flush_cnt;
  int checks = 0, errors = 0;
  logic [3:0] esc = 0, efc = 0;
  logic eme = 0;
  typedef struct { string tag; logic [19:0] exp; } item_t;
  item_t sb[$];
  localparam logic [6:0] NONE = 7'b0000000, LW = 7'b1100010, BR = 7'b0000110, MS = 7'b1111001;

  hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .clr_cnt(clr_cnt), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF),
    .StallD(StallD), .StallE(StallE), .StallM(StallM), .FlushD(FlushD), .FlushE(FlushE),
    .FlushW(FlushW), .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] fa, input logic [1:0] fb, input logic [6:0] sf);
    item_t it, got;
    logic [19:0] obs;
    it.tag = tag;
    it.exp = {fa, fb, sf, eme, esc, efc};
    sb.push_back(it);
    @(negedge clk);
    got = sb.pop_front();
    obs = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           mem_err, stall_cnt, flush_cnt};
    checks++;
    assert (obs === got.exp) else begin
      errors++;
      $error("FAIL %s: got %h exp %h", got.tag, obs, got.exp);
    end
    @(posedge clk);
    #1;
    if (reset || clr_cnt) begin
      esc = 0;
      efc = 0;
    end else begin
      if (sf[6] && esc != 4'hF) esc = esc + 1;
      if (sf[2] && efc != 4'hF) efc = efc + 1;
    end
  endtask

  initial begin
    MemReqM = 1; Rs1E = 5; RdM = 5; RegWriteM = 1;
    chk("reset_quiet", 2'b00, 2'b00, NONE);
    reset = 0; MemReqM = 0;
    RdW = 5; RegWriteW = 1;
    chk("fwd_m_prio", 2'b10, 2'b00, NONE);
    RdM = 0;
    chk("fwd_w", 2'b01, 2'b00, NONE);
    RdW = 0;
    chk("fwd_rd0", 2'b00, 2'b00, NONE);
    Rs2E = 9; RdM = 9; RdW = 9;
    chk("fwdb_m", 2'b00, 2'b10, NONE);
    RegWriteM = 0;
    chk("fwdb_w", 2'b00, 2'b01, NONE);
    RegWriteW = 0; Rs1E = 0; Rs2E = 0; RdM = 0; RdW = 0;
    ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
    chk("load_use", 2'b00, 2'b00, LW);
    ResultSrcE0 = 0;
    chk("load_use_cnt", 2'b00, 2'b00, NONE);
    ResultSrcE0 = 1; RdE = 0; Rs2D = 0;
    chk("load_rd0", 2'b00, 2'b00, NONE);
    RdE = 7; Rs2D = 7; PCSrcE = 1;
    chk("branch_over_lw", 2'b00, 2'b00, BR);
    PCSrcE = 0; ResultSrcE0 = 0;
    chk("branch_cnt", 2'b00, 2'b00, NONE);
    MemReqM = 1; MemReadyM = 1;
    chk("mem_ready_first", 2'b00, 2'b00, NONE);
    MemReadyM = 0;
    chk("mem_wait1", 2'b00, 2'b00, MS);
    PCSrcE = 1;
    chk("mem_wait2_br", 2'b00, 2'b00, MS);
    PCSrcE = 0;
    chk("mem_wait3", 2'b00, 2'b00, MS);
    MemReadyM = 1;
    chk("mem_ready", 2'b00, 2'b00, NONE);
    MemReadyM = 0; MemReqM = 0;
    chk("mem_after", 2'b00, 2'b00, NONE);
    MemReqM = 1;
    for (int i = 0; i < 4; i++) chk("to_stall", 2'b00, 2'b00, MS);
    chk("to_release", 2'b00, 2'b00, NONE);
    eme = 1; MemReqM = 0;
    chk("to_err", 2'b00, 2'b00, NONE);
    chk("to_err_sticky", 2'b00, 2'b00, NONE);
    MemReqM = 1;
    chk("rm_wait1", 2'b00, 2'b00, MS);
    chk("rm_wait2", 2'b00, 2'b00, MS);
    reset = 1; esc = 0; efc = 0; eme = 0; RegWriteM = 1; RdM = 3; Rs1E = 3;
    chk("reset_mid", 2'b00, 2'b00, NONE);
    reset = 0; RegWriteM = 0; RdM = 0; Rs1E = 0;
    for (int i = 0; i < 4; i++) chk("rr_stall", 2'b00, 2'b00, MS);
    chk("rr_release", 2'b00, 2'b00, NONE);
    eme = 1; MemReqM = 0;
    chk("rr_err", 2'b00, 2'b00, NONE);
    ResultSrcE0 = 1; RdE = 7; Rs1D = 7; Rs2D = 0;
    for (int i = 0; i < 20; i++) chk("sat", 2'b00, 2'b00, LW);
    clr_cnt = 1;
    chk("clr_vs_stall", 2'b00, 2'b00, LW);
    clr_cnt = 0; ResultSrcE0 = 0;
    chk("clr_done", 2'b00, 2'b00, NONE);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
